// File: rtl/reg_scoreboard_if.sv
// Decode/writeback bundle for the register hazard scoreboard.
// The master side is the pipeline (decode + writeback); the slave side is the scoreboard.
interface reg_scoreboard_if #(
  parameter int REGNUM  = 8,
  parameter int STALL_W = 16
);
  logic               issue_valid;
  logic               issue_ready;
  logic [3:0]         srcA;
  logic [3:0]         srcB;
  logic [3:0]         dstE;
  logic [3:0]         dstM;
  logic [3:0]         wb_dstE;
  logic [3:0]         wb_dstM;
  logic               flush;
  logic [REGNUM-1:0]  busy_mask;
  logic [STALL_W-1:0] stall_count;
  logic               err;

  modport master (
    output issue_valid, srcA, srcB, dstE, dstM, wb_dstE, wb_dstM, flush,
    input  issue_ready, busy_mask, stall_count, err
  );

  modport slave (
    input  issue_valid, srcA, srcB, dstE, dstM, wb_dstE, wb_dstM, flush,
    output issue_ready, busy_mask, stall_count, err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Hazard scoreboard: one pending-write counter per architectural register.
// Decode is held off while a source has an outstanding write or a destination
// counter is full; writeback retires entries every cycle regardless of issue.
// Register IDs at or above REGNUM (including NOREG = 4'hF) never match any
// counter, so they are ignored on every port without extra decoding.
module reg_scoreboard #(
  parameter int REGNUM  = 8,
  parameter int CNT_W   = 2,
  parameter int STALL_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  reg_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [REGNUM-1:0]  haz_vec;
  logic [REGNUM-1:0]  sat_vec;
  logic [REGNUM-1:0]  inc_vec;
  logic [REGNUM-1:0]  dec_vec;
  logic [REGNUM-1:0]  underflow_vec;
  logic [REGNUM-1:0]  busy_next;
  logic [REGNUM-1:0]  busy_reg;
  logic [STALL_W-1:0] stall_reg;
  logic               err_reg;
  logic               ready;
  logic               accept;

  // Hazard and saturation look only at registered counts; a retire in the
  // same cycle is not credited because the regfile writes at the edge.
  assign ready  = !(|haz_vec) && !(|sat_vec) && !sb.flush;
  assign accept = sb.issue_valid && ready;

  generate
    for (genvar gi = 0; gi < REGNUM; gi++) begin : g_reg
      localparam logic [3:0] ID = 4'(gi);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Matching either port sets a single bit, so dstE == dstM (or
      // wb_dstE == wb_dstM) naturally counts once.
      assign inc_vec[gi]       = accept && ((sb.dstE == ID) || (sb.dstM == ID));
      assign dec_vec[gi]       = (sb.wb_dstE == ID) || (sb.wb_dstM == ID);
      assign haz_vec[gi]       = ((sb.srcA == ID) || (sb.srcB == ID)) && (cnt_q != '0);
      assign sat_vec[gi]       = ((sb.dstE == ID) || (sb.dstM == ID)) && (cnt_q == CNT_MAX);
      assign underflow_vec[gi] = !sb.flush && dec_vec[gi] && (cnt_q == '0);

      // Counter next state: flush clears, inc+dec cancels, underflow holds at 0.
      always_comb begin
        cnt_d = cnt_q;
        if (sb.flush) begin
          cnt_d = '0;
        end else if (inc_vec[gi] && !dec_vec[gi]) begin
          cnt_d = cnt_q + 1'b1;
        end else if (!inc_vec[gi] && dec_vec[gi] && (cnt_q != '0)) begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      assign busy_next[gi] = (cnt_d != '0);

      // Pending-write counter register.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  // Busy mask mirrors the post-update counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  // Saturating count of cycles where decode was held off (flush cycles excluded).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_reg <= '0;
    end else if (sb.issue_valid && !ready && !sb.flush && (stall_reg != '1)) begin
      stall_reg <= stall_reg + 1'b1;
    end
  end

  // Sticky retire-underflow flag; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_reg <= 1'b0;
    end else if (|underflow_vec) begin
      err_reg <= 1'b1;
    end
  end

  assign sb.issue_ready = ready;
  assign sb.busy_mask   = busy_reg;
  assign sb.stall_count = stall_reg;
  assign sb.err         = err_reg;

endmodule
